udma_hyper_txn_sched: RTL and testbench

UDMA_HYPER_TXN_SCHED -- requirements
Module: udma_hyper_txn_sched

---
 rtl/udma_hyper_pkg.sv | 19 +
 rtl/udma_hyper_rr_arb2.sv | 36 +++
 rtl/udma_hyper_txn_sched.sv | 144 ++++++++++++++
 tb/tb_udma_hyper_txn_sched.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/udma_hyper_pkg.sv
// Shared types and defaults for the HyperBus uDMA transaction scheduler.
package udma_hyper_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned LEN_W_DEF  = 16;
   localparam int unsigned TO_W_DEF   = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_END   = 2'd3
   } state_e;

   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/udma_hyper_rr_arb2.sv
// Two-input round-robin arbiter; the last-grant register favours the
// requester that lost the previous grant.
module udma_hyper_rr_arb2
   import udma_hyper_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req_i,
   input  logic       en_i,
   output logic [1:0] gnt_o,
   output logic       gnt_id_o
);

   logic last_q;
   logic last_d;
   logic fire;

   always_comb begin
      gnt_id_o = req_i[1];
      if (req_i == 2'b11) begin
         gnt_id_o = ~last_q;
      end
      fire   = en_i & (|req_i);
      gnt_o  = fire ? onehot2(gnt_id_o) : 2'b00;
      last_d = fire ? gnt_id_o : last_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/udma_hyper_txn_sched.sv
// Arbitrates two uDMA requesters and runs one HyperBus transaction at a
// time through issue, busy wait (with optional timeout) and end-of-transfer.
module udma_hyper_txn_sched
   import udma_hyper_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned LEN_W  = LEN_W_DEF,
   parameter int unsigned TO_W   = TO_W_DEF
) (
   input  logic                sys_clk_i,
   input  logic                rst_ni,
   input  logic [1:0]          req_valid_i,
   output logic [1:0]          req_ready_o,
   input  logic [2*ADDR_W-1:0] req_addr_i,
   input  logic [2*LEN_W-1:0]  req_len_i,
   input  logic [1:0]          req_rw_i,
   output logic                cmd_valid_o,
   input  logic                cmd_ready_i,
   output logic [ADDR_W-1:0]   cmd_addr_o,
   output logic [LEN_W-1:0]    cmd_len_o,
   output logic                cmd_rw_o,
   output logic                cmd_id_o,
   input  logic                done_i,
   input  logic [TO_W-1:0]     cfg_timeout_i,
   output logic                busy_o,
   output logic [1:0]          evt_eot_o,
   output logic                evt_timeout_o
);

   state_e            state_q, state_d;
   logic [TO_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              rw_q, rw_d;
   logic              id_q, id_d;
   logic              busy_q, busy_d;

   logic              arb_en;
   logic [1:0]        gnt;
   logic              gnt_id;
   logic [ADDR_W-1:0] sel_addr;
   logic [LEN_W-1:0]  sel_len;
   logic              sel_rw;
   logic              evt_to;

   // Grant only while idle; gating with rst_ni keeps ready low in reset.
   assign arb_en = (state_q == ST_IDLE) & rst_ni;

   udma_hyper_rr_arb2 u_arb (
      .clk_i    (sys_clk_i),
      .rst_ni   (rst_ni),
      .req_i    (req_valid_i),
      .en_i     (arb_en),
      .gnt_o    (gnt),
      .gnt_id_o (gnt_id)
   );

   always_comb begin
      sel_addr = req_addr_i[ADDR_W-1:0];
      sel_len  = req_len_i[LEN_W-1:0];
      sel_rw   = req_rw_i[0];
      if (gnt_id) begin
         sel_addr = req_addr_i[2*ADDR_W-1:ADDR_W];
         sel_len  = req_len_i[2*LEN_W-1:LEN_W];
         sel_rw   = req_rw_i[1];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      len_d   = len_q;
      rw_d    = rw_q;
      id_d    = id_q;
      evt_to  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (|gnt) begin
               addr_d  = sel_addr;
               len_d   = sel_len;
               rw_d    = sel_rw;
               id_d    = gnt_id;
               state_d = (sel_len != '0) ? ST_ISSUE : ST_END;
            end
         end
         ST_ISSUE: begin
            if (cmd_ready_i) begin
               cnt_d   = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + TO_W'(1);
            // done_i has priority over an expiring timeout
            if (done_i) begin
               state_d = ST_END;
            end else if ((cfg_timeout_i != '0) &&
                         (cnt_q == cfg_timeout_i - TO_W'(1))) begin
               evt_to  = 1'b1;
               state_d = ST_END;
            end
         end
         ST_END: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge sys_clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         rw_q    <= 1'b0;
         id_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         rw_q    <= rw_d;
         id_q    <= id_d;
         busy_q  <= busy_d;
      end
   end

   assign req_ready_o   = gnt;
   assign cmd_valid_o   = (state_q == ST_ISSUE);
   assign cmd_addr_o    = addr_q;
   assign cmd_len_o     = len_q;
   assign cmd_rw_o      = rw_q;
   assign cmd_id_o      = id_q;
   assign busy_o        = busy_q;
   assign evt_eot_o     = (state_q == ST_END) ? onehot2(id_q) : 2'b00;
   assign evt_timeout_o = evt_to;

endmodule

// File: tb/tb_udma_hyper_txn_sched.sv
// Randomized transaction-level bench for udma_hyper_txn_sched.
module tb_udma_hyper_txn_sched;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_addr;
   logic [31:0] req_len;
   logic [1:0]  req_rw;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   logic [15:0] cmd_len;
   logic        cmd_rw;
   logic        cmd_id;
   logic        done;
   logic [15:0] cfg;
   logic        busy;
   logic [1:0]  eot;
   logic        to;

   int n_chk;
   int n_pass;
   logic last_w;

   udma_hyper_txn_sched dut (
      .sys_clk_i     (clk),
      .rst_ni        (rst_n),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_addr_i    (req_addr),
      .req_len_i     (req_len),
      .req_rw_i      (req_rw),
      .cmd_valid_o   (cmd_valid),
      .cmd_ready_i   (cmd_ready),
      .cmd_addr_o    (cmd_addr),
      .cmd_len_o     (cmd_len),
      .cmd_rw_o      (cmd_rw),
      .cmd_id_o      (cmd_id),
      .done_i        (done),
      .cfg_timeout_i (cfg),
      .busy_o        (busy),
      .evt_eot_o     (eot),
      .evt_timeout_o (to)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [1:0] oh(input logic i);
      return i ? 2'b10 : 2'b01;
   endfunction

   task automatic chk_quiet(input string tag);
      chk({tag, "_rdy"}, req_ready, 2'b00);
      chk({tag, "_cv"}, cmd_valid, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_eot"}, eot, 2'b00);
      chk({tag, "_to"}, to, 1'b0);
   endtask

   // One full transaction; done_dly < 0 means done_i is never sent.
   task automatic run_txn(input logic [1:0] v,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input logic [15:0] l0, input logic [15:0] l1,
                          input logic [1:0] rw, input int rdy_dly,
                          input int done_dly, input logic [15:0] cfg_v,
                          input bit chg);
      logic        w;
      logic [31:0] ea;
      logic [15:0] el;
      logic        erw;
      logic        exp_to;
      bit          fin;
      @(negedge clk);
      cfg       = cfg_v;
      req_valid = v;
      req_addr  = {a1, a0};
      req_len   = {l1, l0};
      req_rw    = rw;
      done      = 1'($urandom_range(0, 1));
      cmd_ready = 1'($urandom_range(0, 1));
      #1;
      w = (v == 2'b11) ? ~last_w : v[1];
      chk("grant", req_ready, oh(w));
      chk("idle_busy", busy, 1'b0);
      chk("idle_cv", cmd_valid, 1'b0);
      chk("idle_to", to, 1'b0);
      last_w = w;
      ea  = w ? a1 : a0;
      el  = w ? l1 : l0;
      erw = w ? rw[1] : rw[0];
      @(negedge clk);
      req_valid = 2'b00;
      done      = 1'b0;
      cmd_ready = 1'b0;
      if (el != 16'd0) begin
         for (int k = 0; k <= rdy_dly; k++) begin
            if (k > 0) @(negedge clk);
            cmd_ready = (k == rdy_dly);
            done      = 1'($urandom_range(0, 1));
            #1;
            chk("cmd_valid", cmd_valid, 1'b1);
            chk("cmd_addr", cmd_addr, ea);
            chk("cmd_len", cmd_len, el);
            chk("cmd_rw", cmd_rw, erw);
            chk("cmd_id", cmd_id, w);
            chk("issue_busy", busy, 1'b1);
            chk("issue_eot", eot, 2'b00);
            chk("issue_rdy", req_ready, 2'b00);
         end
         @(negedge clk);
         cmd_ready = 1'b0;
         fin = 1'b0;
         for (int wc = 0; wc < 200 && !fin; wc++) begin
            if (wc > 0) @(negedge clk);
            if (chg && wc == 2) cfg = 16'($urandom_range(3, 12));
            done = (wc == done_dly);
            #1;
            exp_to = !done && cfg != 16'd0 && wc == int'(cfg) - 1;
            chk("wait_to", to, exp_to);
            chk("wait_cv", cmd_valid, 1'b0);
            chk("wait_busy", busy, 1'b1);
            chk("wait_eot", eot, 2'b00);
            if (done || exp_to) fin = 1'b1;
         end
         if (!fin) chk("wait_bound", 1'b0, 1'b1);
         @(negedge clk);
      end
      done = 1'($urandom_range(0, 1));
      #1;
      chk("end_eot", eot, oh(w));
      chk("end_to", to, 1'b0);
      chk("end_cv", cmd_valid, 1'b0);
      chk("end_busy", busy, 1'b1);
      @(negedge clk);
      done = 1'b0;
      #1;
      chk_quiet("post");
   endtask

   initial begin
      logic [1:0]  v;
      logic [15:0] l0, l1, c;
      int          dd;
      n_chk     = 0;
      n_pass    = 0;
      last_w    = 1'b1;
      rst_n     = 1'b0;
      req_valid = 2'b00;
      req_addr  = '0;
      req_len   = '0;
      req_rw    = 2'b00;
      cmd_ready = 1'b0;
      done      = 1'b0;
      cfg       = '0;
      #12;
      chk_quiet("reset");
      chk("reset_addr", cmd_addr, 32'd0);
      chk("reset_len", cmd_len, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_txn(2'b01, 32'h1000, 32'h0, 16'd64, 16'd0, 2'b01,
              0, 10, 16'd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         run_txn(2'b11, 32'hA000 + i, 32'hB000 + i, 16'd8, 16'd9,
                 2'b10, 0, 4, 16'd0, 1'b0);
      end
      run_txn(2'b10, 32'h0, 32'h2222, 16'd0, 16'd32, 2'b00,
              7, 2, 16'd0, 1'b0);
      run_txn(2'b01, 32'h3000, 32'h0, 16'd4, 16'd0, 2'b00,
              1, -1, 16'd8, 1'b0);
      run_txn(2'b01, 32'h3004, 32'h0, 16'd4, 16'd0, 2'b01,
              0, 7, 16'd8, 1'b0);
      run_txn(2'b10, 32'h0, 32'h4000, 16'd5, 16'd0, 2'b11,
              0, 3, 16'd0, 1'b0);
      run_txn(2'b01, 32'h5000, 32'h0, 16'd4, 16'd0, 2'b00,
              0, -1, 16'd1, 1'b0);

      // Abort in WAIT via asynchronous reset.
      @(negedge clk);
      req_valid = 2'b01;
      req_addr  = {32'h0, 32'h6000};
      req_len   = {16'd0, 16'd16};
      @(negedge clk);
      req_valid = 2'b00;
      cmd_ready = 1'b1;
      cfg       = 16'd3;
      @(negedge clk);
      cmd_ready = 1'b0;
      #2;
      chk("pre_rst_busy", busy, 1'b1);
      rst_n     = 1'b0;
      req_valid = 2'b11;
      #1;
      chk_quiet("rst");
      chk("rst_addr", cmd_addr, 32'd0);
      chk("rst_id", cmd_id, 1'b0);
      @(negedge clk);
      req_valid = 2'b00;
      rst_n     = 1'b1;
      last_w    = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         chk_quiet("after_rst");
      end
      run_txn(2'b11, 32'h7000, 32'h7100, 16'd2, 16'd3, 2'b01,
              0, 1, 16'd0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         v  = 2'($urandom_range(1, 3));
         l0 = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
         l1 = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
         c  = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
         dd = $urandom_range(0, 15);
         if (c != 16'd0 && $urandom_range(0, 2) == 0) dd = -1;
         run_txn(v, $urandom, $urandom, l0, l1, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 4), dd, c,
                 c != 16'd0 && $urandom_range(0, 3) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
